// File: rtl/shift_reg_seq_if.sv
// shift_reg_seq_if: command/data bundle for the universal shift register
interface shift_reg_seq_if #(parameter int WIDTH = 8);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic             s_in;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] p_out;
  logic             s_out;
  logic             busy;
  logic             done;
  modport master (output cmd_valid, cmd_mode, cmd_count, abort, s_in, p_in,
                  input  cmd_ready, p_out, s_out, busy, done);
  modport slave  (input  cmd_valid, cmd_mode, cmd_count, abort, s_in, p_in,
                  output cmd_ready, p_out, s_out, busy, done);
endinterface

// File: rtl/shift_reg_seq.sv
// shift_reg_seq: command-driven universal shift register, one bit per clock
module shift_reg_seq #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  shift_reg_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [2:0] M_NOP = 3'b000, M_SHR = 3'b001, M_SHL = 3'b010, M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100, M_ROL = 3'b101, M_ASR = 3'b110, M_CLR = 3'b111;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_p, w_p_nx, w_stp;
  logic             r_s, w_s_nx, w_sbit;
  logic [CNT_W-1:0] r_rem, w_rem_nx;
  logic [2:0]       r_mode, w_mode_nx, w_smode;
  logic             r_done, w_done_nx;
  logic             w_acc, w_shift_cmd;
  assign bus.cmd_ready = (r_state == IDLE) && !rst;
  assign bus.p_out     = r_p;
  assign bus.s_out     = r_s;
  assign bus.busy      = (r_state == BUSY);
  assign bus.done      = r_done;
  assign w_acc         = bus.cmd_valid && bus.cmd_ready;
  assign w_smode       = (r_state == IDLE) ? bus.cmd_mode : r_mode;
  assign w_shift_cmd   = (bus.cmd_mode != M_NOP) && (bus.cmd_mode != M_LOAD) && (bus.cmd_mode != M_CLR);
  // one single-bit step of the active mode applied to the current contents
  always_comb begin
    w_stp  = (w_smode == M_SHR) ? {bus.s_in, r_p[WIDTH-1:1]} :
             (w_smode == M_SHL) ? {r_p[WIDTH-2:0], bus.s_in} :
             (w_smode == M_ROR) ? {r_p[0], r_p[WIDTH-1:1]} :
             (w_smode == M_ROL) ? {r_p[WIDTH-2:0], r_p[WIDTH-1]} :
                                  {r_p[WIDTH-1], r_p[WIDTH-1:1]};
    w_sbit = (w_smode == M_SHL || w_smode == M_ROL) ? r_p[WIDTH-1] : r_p[0];
  end
  // next-state: accept in IDLE, step/abort in BUSY
  always_comb begin
    w_state_nx = r_state;
    w_p_nx     = r_p;
    w_s_nx     = r_s;
    w_rem_nx   = r_rem;
    w_mode_nx  = r_mode;
    w_done_nx  = 1'b0;
    if (r_state == BUSY) begin
      if (bus.abort) begin
        w_state_nx = IDLE;
        w_rem_nx   = '0;
      end else begin
        w_p_nx   = w_stp;
        w_s_nx   = w_sbit;
        w_rem_nx = r_rem - CNT_W'(1);
        if (r_rem == CNT_W'(1)) begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
        end
      end
    end else if (w_acc) begin
      w_mode_nx = bus.cmd_mode;
      w_done_nx = 1'b1;
      if (bus.cmd_mode == M_LOAD) w_p_nx = bus.p_in;
      else if (bus.cmd_mode == M_CLR) w_p_nx = '0;
      else if (w_shift_cmd && bus.cmd_count != '0) begin
        w_p_nx   = w_stp;
        w_s_nx   = w_sbit;
        w_rem_nx = bus.cmd_count - CNT_W'(1);
        if (bus.cmd_count > CNT_W'(1)) begin
          w_state_nx = BUSY;
          w_done_nx  = 1'b0;
        end
      end
    end
  end
  // state and datapath registers, reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_p     <= '0;
      r_s     <= 1'b0;
      r_rem   <= '0;
      r_mode  <= M_NOP;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_p     <= w_p_nx;
      r_s     <= w_s_nx;
      r_rem   <= w_rem_nx;
      r_mode  <= w_mode_nx;
      r_done  <= w_done_nx;
    end
  end
endmodule

// File: tb/tb_shift_reg_seq.sv
// tb_shift_reg_seq: directed vectors and corner-case sequences for shift_reg_seq
module tb_shift_reg_seq;
  localparam logic [2:0] NOP = 3'b000, SHR = 3'b001, SHL = 3'b010, LOAD = 3'b011;
  localparam logic [2:0] ROR = 3'b100, ROL = 3'b101, ASR = 3'b110, CLR = 3'b111;
  typedef struct {
    logic [2:0] mode;
    logic [3:0] cnt;
    logic       sin;
    logic [7:0] pin;
    logic [7:0] ep;
    logic       es;
    int         lat;
    int         bsy;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tv[17];
  shift_reg_seq_if #(.WIDTH(8)) bus ();
  shift_reg_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic set_cmd(input logic [2:0] m, input logic [3:0] c, input logic si, input logic [7:0] pi);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    bus.cmd_count = c;
    bus.s_in      = si;
    bus.p_in      = pi;
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int k;
    int b;
    set_cmd(v.mode, v.cnt, v.sin, v.pin);
    tick();
    bus.cmd_valid = 1'b0;
    k = 1;
    b = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) b++;
      tick();
      k++;
    end
    chk($sformatf("vec%0d latency", idx), k, v.lat);
    chk($sformatf("vec%0d busy_cycles", idx), b, v.bsy);
    chk($sformatf("vec%0d p_out", idx), bus.p_out, v.ep);
    chk($sformatf("vec%0d s_out", idx), bus.s_out, v.es);
    tick();
    chk($sformatf("vec%0d done_width", idx), bus.done, 1'b0);
  endtask
  initial begin
    tv[0]  = '{LOAD, 4'd0,  1'b0, 8'hA5, 8'hA5, 1'b0, 1, 0};
    tv[1]  = '{LOAD, 4'd0,  1'b0, 8'h81, 8'h81, 1'b0, 1, 0};
    tv[2]  = '{SHR,  4'd3,  1'b1, 8'h00, 8'hF0, 1'b0, 3, 2};
    tv[3]  = '{LOAD, 4'd0,  1'b0, 8'h3C, 8'h3C, 1'b0, 1, 0};
    tv[4]  = '{ROL,  4'd8,  1'b0, 8'h00, 8'h3C, 1'b0, 8, 7};
    tv[5]  = '{LOAD, 4'd0,  1'b0, 8'h90, 8'h90, 1'b0, 1, 0};
    tv[6]  = '{ASR,  4'd2,  1'b0, 8'h00, 8'hE4, 1'b0, 2, 1};
    tv[7]  = '{ROR,  4'd1,  1'b0, 8'h00, 8'h72, 1'b0, 1, 0};
    tv[8]  = '{SHL,  4'd0,  1'b1, 8'h00, 8'h72, 1'b0, 1, 0};
    tv[9]  = '{NOP,  4'd0,  1'b0, 8'hFF, 8'h72, 1'b0, 1, 0};
    tv[10] = '{SHL,  4'd3,  1'b1, 8'h00, 8'h97, 1'b1, 3, 2};
    tv[11] = '{CLR,  4'd0,  1'b0, 8'hFF, 8'h00, 1'b1, 1, 0};
    tv[12] = '{LOAD, 4'd0,  1'b0, 8'h81, 8'h81, 1'b1, 1, 0};
    tv[13] = '{ROR,  4'd9,  1'b0, 8'h00, 8'hC0, 1'b1, 9, 8};
    tv[14] = '{SHR,  4'd10, 1'b0, 8'h00, 8'h00, 1'b0, 10, 9};
    tv[15] = '{LOAD, 4'd0,  1'b0, 8'h80, 8'h80, 1'b0, 1, 0};
    tv[16] = '{ASR,  4'd9,  1'b0, 8'h00, 8'hFF, 1'b1, 9, 8};
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = NOP;
    bus.cmd_count = '0;
    bus.abort     = 1'b0;
    bus.s_in      = 1'b0;
    bus.p_in      = '0;
    tick();
    tick();
    chk("rst cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst p_out", bus.p_out, 8'h00);
    chk("rst s_out", bus.s_out, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    rst = 1'b0;
    #1;
    chk("post-rst cmd_ready", bus.cmd_ready, 1'b1);
    for (int i = 0; i < 17; i++) run_vec(tv[i], i);
    set_cmd(LOAD, 4'd0, 1'b0, 8'h81);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    set_cmd(SHR, 4'd3, 1'b1, 8'h00);
    tick();
    chk("shr step1 p_out", bus.p_out, 8'hC0);
    chk("shr step1 s_out", bus.s_out, 1'b1);
    chk("shr step1 busy", bus.busy, 1'b1);
    chk("shr step1 cmd_ready", bus.cmd_ready, 1'b0);
    set_cmd(LOAD, 4'd0, 1'b1, 8'hFF);
    tick();
    bus.cmd_valid = 1'b0;
    chk("shr step2 p_out", bus.p_out, 8'hE0);
    chk("shr step2 s_out", bus.s_out, 1'b0);
    tick();
    chk("shr step3 p_out", bus.p_out, 8'hF0);
    chk("shr step3 s_out", bus.s_out, 1'b0);
    chk("shr step3 busy", bus.busy, 1'b0);
    chk("shr step3 done", bus.done, 1'b1);
    tick();
    chk("shr after done", bus.done, 1'b0);
    set_cmd(LOAD, 4'd0, 1'b0, 8'h01);
    tick();
    set_cmd(SHL, 4'd5, 1'b0, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    chk("abort step1 p_out", bus.p_out, 8'h02);
    tick();
    chk("abort step2 p_out", bus.p_out, 8'h04);
    chk("abort step2 busy", bus.busy, 1'b1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort hold p_out", bus.p_out, 8'h04);
    chk("abort busy", bus.busy, 1'b0);
    chk("abort done", bus.done, 1'b0);
    chk("abort cmd_ready", bus.cmd_ready, 1'b1);
    set_cmd(LOAD, 4'd0, 1'b0, 8'h5A);
    tick();
    bus.cmd_valid = 1'b0;
    chk("after abort load p_out", bus.p_out, 8'h5A);
    chk("after abort load done", bus.done, 1'b1);
    set_cmd(LOAD, 4'd0, 1'b0, 8'hFF);
    tick();
    set_cmd(SHR, 4'd4, 1'b0, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    chk("rstmid step1 p_out", bus.p_out, 8'h7F);
    tick();
    chk("rstmid step2 p_out", bus.p_out, 8'h3F);
    chk("rstmid step2 s_out", bus.s_out, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    rst = 1'b0;
    chk("rstmid p_out", bus.p_out, 8'h00);
    chk("rstmid s_out", bus.s_out, 1'b0);
    chk("rstmid busy", bus.busy, 1'b0);
    chk("rstmid done", bus.done, 1'b0);
    tick();
    chk("rstmid done later", bus.done, 1'b0);
    set_cmd(LOAD, 4'd0, 1'b0, 8'h6B);
    tick();
    set_cmd(SHL, 4'd0, 1'b1, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    chk("shl0 p_out", bus.p_out, 8'h6B);
    chk("shl0 done", bus.done, 1'b1);
    tick();
    chk("shl0 done width", bus.done, 1'b0);
    set_cmd(LOAD, 4'd0, 1'b0, 8'h55);
    tick();
    chk("b2b load p_out", bus.p_out, 8'h55);
    chk("b2b load done", bus.done, 1'b1);
    set_cmd(CLR, 4'd0, 1'b0, 8'hAA);
    tick();
    chk("b2b clear p_out", bus.p_out, 8'h00);
    chk("b2b clear done", bus.done, 1'b1);
    set_cmd(NOP, 4'd0, 1'b0, 8'hAA);
    tick();
    bus.cmd_valid = 1'b0;
    chk("b2b nop p_out", bus.p_out, 8'h00);
    chk("b2b nop done", bus.done, 1'b1);
    tick();
    chk("b2b done end", bus.done, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
